decode_stage: RTL and testbench

- RV32I decode pipeline stage. Sits between fetch and the ALU and produces everything the ALU consumes: operands A/B, opcode, funct3, funct7.
- Accepts one instruction plus PC per handshake. Drives rs1/rs2 read addresses to an async-read register file. Registers the decoded bundle behind a valid/ready output interface with stall and flush support.

---
 rtl/decode_stage.sv | 212 +++++++++++++++++++++
 tb/tb_decode_stage.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32I decode stage: turns one fetched instruction into ALU operands and control, held in a valid/ready output register.
// Optional write-back forwarding into the operand path is enabled with DECODE_WB_FWD_EN.
module decode_stage #(
  parameter bit ZERO_X0 = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
`ifdef DECODE_WB_FWD_EN
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [31:0] rs1_val,
  output logic [31:0] rs2_val,
  output logic [4:0]  rd,
  output logic        rd_we,
  output logic [31:0] pc_out,
  output logic        illegal
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_ZERO = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  logic [6:0]  inst_opcode;
  logic [2:0]  inst_funct3;
  logic [6:0]  inst_funct7;
  logic [4:0]  inst_rd;

  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  logic [31:0] src1;
  logic [31:0] src2;

  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic [2:0]  dec_funct3;
  logic [6:0]  dec_funct7;
  logic        dec_illegal;
  logic        dec_writes_rd;
  logic        dec_rd_we;

  logic        in_fire;

  assign inst_opcode = in_inst[6:0];
  assign inst_funct3 = in_inst[14:12];
  assign inst_funct7 = in_inst[31:25];
  assign inst_rd     = in_inst[11:7];

  assign rs1_addr = in_inst[19:15];
  assign rs2_addr = in_inst[24:20];

  assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u = {in_inst[31:12], 12'b0};
  assign imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

  assign in_ready = !flush && (!out_valid || out_ready);
  assign in_fire  = in_valid && in_ready;

  // Source values: forwarded write-back data beats the register file, but x0 is always zero.
  always_comb begin
    src1 = rs1_data;
    src2 = rs2_data;
`ifdef DECODE_WB_FWD_EN
    if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs1_addr)) src1 = wb_data;
    if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs2_addr)) src2 = wb_data;
`endif
    if (ZERO_X0 && (rs1_addr == 5'd0)) src1 = 32'd0;
    if (ZERO_X0 && (rs2_addr == 5'd0)) src2 = 32'd0;
  end

  always_comb begin
    dec_a         = src1;
    dec_b         = src2;
    dec_funct3    = inst_funct3;
    dec_funct7    = inst_funct7;
    dec_illegal   = 1'b0;
    dec_writes_rd = 1'b0;

    case (inst_opcode)
      OPC_LUI: begin
        dec_a         = 32'd0;
        dec_b         = imm_u;
        dec_writes_rd = 1'b1;
      end
      OPC_AUIPC: begin
        dec_a         = in_pc;
        dec_b         = imm_u;
        dec_writes_rd = 1'b1;
      end
      OPC_LOAD: begin
        dec_b         = imm_i;
        dec_writes_rd = 1'b1;
      end
      OPC_STORE: begin
        dec_b = imm_s;
      end
      OPC_BRANCH: begin
        dec_a = in_pc;
        dec_b = imm_b;
      end
      OPC_JAL: begin
        dec_a         = in_pc;
        dec_b         = imm_j;
        dec_funct3    = 3'd0;
        dec_funct7    = F7_ZERO;
        dec_writes_rd = 1'b1;
      end
      OPC_JALR: begin
        dec_b         = imm_i;
        dec_funct3    = 3'd0;
        dec_funct7    = F7_ZERO;
        dec_writes_rd = 1'b1;
        dec_illegal   = (inst_funct3 != 3'd0);
      end
      OPC_OPIMM: begin
        dec_writes_rd = 1'b1;
        // Shifts carry shamt in the immediate; other ops must not let imm[10] look like SUB/SRA.
        if ((inst_funct3 == 3'd1) || (inst_funct3 == 3'd5)) begin
          dec_b      = {27'b0, in_inst[24:20]};
          dec_funct7 = inst_funct7;
          if (inst_funct3 == 3'd1)
            dec_illegal = (inst_funct7 != F7_ZERO);
          else
            dec_illegal = (inst_funct7 != F7_ZERO) && (inst_funct7 != F7_ALT);
        end else begin
          dec_b      = imm_i;
          dec_funct7 = F7_ZERO;
        end
      end
      OPC_OP: begin
        dec_writes_rd = 1'b1;
        if ((inst_funct7 != F7_ZERO) && (inst_funct7 != F7_ALT))
          dec_illegal = 1'b1;
        else if ((inst_funct7 == F7_ALT) && (inst_funct3 != 3'd0) && (inst_funct3 != 3'd5))
          dec_illegal = 1'b1;
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase

    dec_rd_we = dec_writes_rd && (inst_rd != 5'd0) && !dec_illegal;
  end

  // Output register: reset beats flush, flush beats a new accept, and the bundle holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      alu_a     <= 32'd0;
      alu_b     <= 32'd0;
      opcode    <= 7'd0;
      funct3    <= 3'd0;
      funct7    <= 7'd0;
      rs1_val   <= 32'd0;
      rs2_val   <= 32'd0;
      rd        <= 5'd0;
      rd_we     <= 1'b0;
      pc_out    <= 32'd0;
      illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_fire) begin
      out_valid <= 1'b1;
      alu_a     <= dec_a;
      alu_b     <= dec_b;
      opcode    <= inst_opcode;
      funct3    <= dec_funct3;
      funct7    <= dec_funct7;
      rs1_val   <= src1;
      rs2_val   <= src2;
      rd        <= inst_rd;
      rd_we     <= dec_rd_we;
      pc_out    <= in_pc;
      illegal   <= dec_illegal;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: vector table through a scoreboard queue, plus stall, flush and reset sequences.
// Build with DECODE_WB_FWD_EN defined to also exercise write-back forwarding.
module tb_decode_stage;

  typedef struct {
    int          id;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rs1v;
    logic [31:0] rs2v;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rdx;
    logic        we;
    logic        ill;
    logic        full;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [4:0]  rd;
  logic        rd_we;
  logic [31:0] pc_out;
  logic        illegal;
`ifdef DECODE_WB_FWD_EN
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
`endif

  int   total = 0;
  int   bad   = 0;
  vec_t vecs[$];
  vec_t exp_q[$];
  vec_t cur_exp;

  decode_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
`ifdef DECODE_WB_FWD_EN
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rd(rd), .rd_we(rd_we), .pc_out(pc_out),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(int id, logic [31:0] inst, logic [31:0] pc, logic [31:0] a,
                              logic [31:0] b, logic [31:0] rs1v, logic [31:0] rs2v,
                              logic [2:0] f3, logic [6:0] f7, logic [4:0] rdx, logic we,
                              logic ill, logic full);
    vec_t v;
    v.id = id; v.inst = inst; v.pc = pc;
    v.wb_we = 1'b0; v.wb_rd = 5'd0; v.wb_data = 32'd0;
    v.a = a; v.b = b; v.rs1v = rs1v; v.rs2v = rs2v;
    v.op = inst[6:0]; v.f3 = f3; v.f7 = f7; v.rdx = rdx;
    v.we = we; v.ill = ill; v.full = full;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic checkOutput(vec_t e);
    string t;
    t = $sformatf("v%0d", e.id);
    chk({t, ".opcode"},  {25'd0, opcode},  {25'd0, e.op});
    chk({t, ".rd"},      {27'd0, rd},      {27'd0, e.rdx});
    chk({t, ".rd_we"},   {31'd0, rd_we},   {31'd0, e.we});
    chk({t, ".illegal"}, {31'd0, illegal}, {31'd0, e.ill});
    chk({t, ".pc_out"},  pc_out,           e.pc);
    if (e.full) begin
      chk({t, ".alu_a"},   alu_a,            e.a);
      chk({t, ".alu_b"},   alu_b,            e.b);
      chk({t, ".funct3"},  {29'd0, funct3},  {29'd0, e.f3});
      chk({t, ".funct7"},  {25'd0, funct7},  {25'd0, e.f7});
      chk({t, ".rs1_val"}, rs1_val,          e.rs1v);
      chk({t, ".rs2_val"}, rs2_val,          e.rs2v);
    end
  endtask

  // Drives one instruction for one cycle; inputs change 2 time units after the rising edge.
  task automatic applyStimulus(vec_t v);
    vec_t    tmp;
    string   t;
    in_valid = 1'b1;
    in_inst  = v.inst;
    in_pc    = v.pc;
`ifdef DECODE_WB_FWD_EN
    wb_we   = v.wb_we;
    wb_rd   = v.wb_rd;
    wb_data = v.wb_data;
`endif
    cur_exp = v;
    #1;
    tmp = v;
    t = $sformatf("v%0d", v.id);
    chk({t, ".rs1_addr"}, {27'd0, rs1_addr}, {27'd0, tmp.inst[19:15]});
    chk({t, ".rs2_addr"}, {27'd0, rs2_addr}, {27'd0, tmp.inst[24:20]});
    @(posedge clk);
    #2;
  endtask

  // Scoreboard: pop on a downstream transfer (or a flush of the held bundle), push on accept.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && (out_ready || flush)) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_out: got out_valid=1 pc=%h, expected no output", pc_out);
        end else begin
          vec_t e;
          e = exp_q.pop_front();
          if (out_ready) checkOutput(e);
        end
      end
      if (in_valid && in_ready) exp_q.push_back(cur_exp);
    end
  end

  task automatic drain(string name);
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #2;
    end
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    vec_t va;
    vec_t vb;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = 32'd0; in_pc = 32'd0;
    rs1_data = 32'd5; rs2_data = 32'd9; out_ready = 1'b1;
`ifdef DECODE_WB_FWD_EN
    wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
`endif
    cur_exp = mk(0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    vecs.push_back(mk( 1, 32'hFFF10093, 32'h0000_0000, 32'd5, 32'hFFFFFFFF, 5, 9, 3'd0, 7'h00, 5'd1,  1, 0, 1));
    vecs.push_back(mk( 2, 32'h40010093, 32'h0000_0004, 32'd5, 32'h00000400, 5, 0, 3'd0, 7'h00, 5'd1,  1, 0, 1));
    vecs.push_back(mk( 3, 32'h123452B7, 32'h0000_0100, 32'd0, 32'h12345000, 5, 9, 3'd5, 7'h09, 5'd5,  1, 0, 1));
    vecs.push_back(mk( 4, 32'h002081B3, 32'h0000_0108, 32'd5, 32'd9,        5, 9, 3'd0, 7'h00, 5'd3,  1, 0, 1));
    vecs.push_back(mk( 5, 32'h402081B3, 32'h0000_010C, 32'd5, 32'd9,        5, 9, 3'd0, 7'h20, 5'd3,  1, 0, 1));
    vecs.push_back(mk( 6, 32'h00309213, 32'h0000_0110, 32'd5, 32'd3,        5, 9, 3'd1, 7'h00, 5'd4,  1, 0, 1));
    vecs.push_back(mk( 7, 32'h4030D213, 32'h0000_0114, 32'd5, 32'd3,        5, 9, 3'd5, 7'h20, 5'd4,  1, 0, 1));
    vecs.push_back(mk( 8, 32'h40309213, 32'h0000_0118, 32'd5, 32'd3,        5, 9, 3'd1, 7'h20, 5'd4,  0, 1, 1));
    vecs.push_back(mk( 9, 32'h402091B3, 32'h0000_011C, 32'd5, 32'd9,        5, 9, 3'd1, 7'h20, 5'd3,  0, 1, 1));
    vecs.push_back(mk(10, 32'h0020A423, 32'h0000_0120, 32'd5, 32'd8,        5, 9, 3'd2, 7'h00, 5'd8,  0, 0, 1));
    vecs.push_back(mk(11, 32'hFE20AE23, 32'h0000_0124, 32'd5, 32'hFFFFFFFC, 5, 9, 3'd2, 7'h7F, 5'h1C, 0, 0, 1));
    vecs.push_back(mk(12, 32'hFE208CE3, 32'h0000_0200, 32'h200, 32'hFFFFFFF8, 5, 9, 3'd0, 7'h7F, 5'h19, 0, 0, 1));
    vecs.push_back(mk(13, 32'h010000EF, 32'h0000_0300, 32'h300, 32'd16,     0, 9, 3'd0, 7'h00, 5'd1,  1, 0, 1));
    vecs.push_back(mk(14, 32'hFFFFF06F, 32'h0000_0304, 32'h304, 32'hFFFFFFFE, 5, 9, 3'd0, 7'h00, 5'd0, 0, 0, 1));
    vecs.push_back(mk(15, 32'h004080E7, 32'h0000_0308, 32'd5, 32'd4,        5, 9, 3'd0, 7'h00, 5'd1,  1, 0, 1));
    vecs.push_back(mk(16, 32'h004090E7, 32'h0000_030C, 32'd5, 32'd4,        5, 9, 3'd0, 7'h00, 5'd1,  0, 1, 1));
    vecs.push_back(mk(17, 32'hFFC0A303, 32'h0000_0310, 32'd5, 32'hFFFFFFFC, 5, 9, 3'd2, 7'h7F, 5'd6,  1, 0, 1));
    vecs.push_back(mk(18, 32'hABCDE397, 32'h0000_0400, 32'h400, 32'hABCDE000, 5, 9, 3'd6, 7'h55, 5'd7, 1, 0, 1));
    vecs.push_back(mk(19, 32'h00000013, 32'h0000_0404, 32'd0, 32'd0,        0, 0, 3'd0, 7'h00, 5'd0,  0, 0, 1));
    vecs.push_back(mk(20, 32'hFFFFFFFF, 32'h0000_0408, 32'd0, 32'd0,        0, 0, 3'd0, 7'h00, 5'h1F, 0, 1, 0));
    vecs.push_back(mk(21, 32'h022081B3, 32'h0000_040C, 32'd5, 32'd9,        5, 9, 3'd0, 7'h01, 5'd3,  0, 1, 1));
`ifdef DECODE_WB_FWD_EN
    va = mk(30, 32'hFFF10093, 32'h0000_0500, 32'd7, 32'hFFFFFFFF, 7, 9, 3'd0, 7'h00, 5'd1, 1, 0, 1);
    va.wb_we = 1'b1; va.wb_rd = 5'd2; va.wb_data = 32'd7;
    vecs.push_back(va);
    va = mk(31, 32'h002081B3, 32'h0000_0504, 32'd5, 32'd7, 5, 7, 3'd0, 7'h00, 5'd3, 1, 0, 1);
    va.wb_we = 1'b1; va.wb_rd = 5'd2; va.wb_data = 32'd7;
    vecs.push_back(va);
    va = mk(32, 32'h00000013, 32'h0000_0508, 32'd0, 32'd0, 0, 0, 3'd0, 7'h00, 5'd0, 0, 0, 1);
    va.wb_we = 1'b1; va.wb_rd = 5'd0; va.wb_data = 32'd7;
    vecs.push_back(va);
`endif

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.alu_a",     alu_a,              32'd0);
    chk("rst.alu_b",     alu_b,              32'd0);
    chk("rst.pc_out",    pc_out,             32'd0);
    chk("rst.rd_we",     {31'd0, rd_we},     32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #2;

    // Back-to-back stream through the table.
    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);
    in_valid = 1'b0;
`ifdef DECODE_WB_FWD_EN
    wb_we = 1'b0;
`endif
    drain("stream.drain");

    // Backpressure: bundle A held for 3 cycles while B waits, then B follows one cycle after release.
    va = vecs[3];
    vb = vecs[2];
    out_ready = 1'b0;
    applyStimulus(va);
    in_valid = 1'b1; in_inst = vb.inst; in_pc = vb.pc; cur_exp = vb;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("stall%0d.in_ready", c),  {31'd0, in_ready},  32'd0);
      chk($sformatf("stall%0d.out_valid", c), {31'd0, out_valid}, 32'd1);
      chk($sformatf("stall%0d.alu_a", c),     alu_a,              va.a);
      chk($sformatf("stall%0d.alu_b", c),     alu_b,              va.b);
      chk($sformatf("stall%0d.pc_out", c),    pc_out,             va.pc);
      @(posedge clk);
      #2;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    @(negedge clk);
    chk("stall.next_valid", {31'd0, out_valid}, 32'd1);
    chk("stall.next_pc",    pc_out,             vb.pc);
    @(posedge clk);
    #2;
    drain("stall.drain");

    // Flush with a held bundle and a new offer: both disappear.
    out_ready = 1'b0;
    applyStimulus(vecs[0]);
    vb = vecs[17];
    in_valid = 1'b1; in_inst = vb.inst; in_pc = vb.pc; cur_exp = vb; flush = 1'b1;
    @(negedge clk);
    chk("flush.in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #2;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("flush.out_valid", {31'd0, out_valid}, 32'd0);
    repeat (3) @(posedge clk);
    #2;
    chk("flush.queue", exp_q.size(), 0);

    // Synchronous reset clears a held bundle; reset also wins over a simultaneous flush.
    out_ready = 1'b0;
    applyStimulus(vecs[2]);
    in_valid = 1'b0;
    rst = 1'b1; flush = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("midrst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst.alu_b",     alu_b,              32'd0);
    chk("midrst.pc_out",    pc_out,             32'd0);
    chk("midrst.rd",        {27'd0, rd},        32'd0);
    chk("midrst.in_ready",  {31'd0, in_ready},  32'd1);
    @(posedge clk);
    #2;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
